dimm_cmd_sequencer: RTL and testbench
=====================================

# dimm_cmd_sequencer

Closed-page DDR4 command sequencer that sits between a request source (host model or emulation frontend) and the `dimm` model. It accepts one read, write or RowClone request at a time, then drives the DIMM command/address pins (cs_n, act_n, A, bg, ba) with ACT → CAS → PRE sequences spaced by programmable timing counters. It also drives the write-data strobe window and flags the read-data window.

## Interface
Parameters:
- RANKS, 1, number of ranks (width of cs_n)
- BGWIDTH, 2, bank-group address bits
- BAWIDTH, 2, bank address bits
- ADDRWIDTH, 17, row/command address bits (A)
- COLWIDTH, 10, column bits (placed in A[COLWIDTH-1:0])
- BL, 8, burst length in clock cycles
- TRCD, 15, cycles from ACT to RD/WR
- TCL, 15, cycles from RD to first read beat
- TWR, 16, cycles from last write beat to PRE
- TRAS, 32, minimum cycles from ACT to PRE (also ACT→ACT for RowClone)
- TRP, 15, cycles from PRE to the next accepted request
- CNTWIDTH, 8, timing counter width

Ports:
- ck_t  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, can accept
- req_op  in  2  00 read, 01 write, 10 RowClone, 11 reserved
- req_rank  in  RANKS  one-hot rank select
- req_bg  in  BGWIDTH  bank group
- req_ba  in  BAWIDTH  bank
- req_row  in  ADDRWIDTH  row (source row for RowClone)
- req_row2  in  ADDRWIDTH  RowClone destination row
- req_col  in  COLWIDTH  column
- cs_n  out  RANKS  chip selects
- act_n  out  1  activate
- A  out  ADDRWIDTH  address/command bus
- bg  out  BGWIDTH  bank group
- ba  out  BAWIDTH  bank
- writing  out  1  write data/strobe drive window
- rd_valid  out  1  read beat expected on dq
- done  out  1  one-cycle pulse on completion
- err  out  1  one-cycle pulse on rejected op

## Operation
- Handshake: a request is accepted on an edge where req_valid & req_ready are both 1. req_ready = 1 only in IDLE. All request fields are latched on acceptance.
- Commands are one-cycle pulses. On a command cycle cs_n = ~req_rank and bg/ba = the latched values. On all other cycles cs_n is all-1, act_n = 1, and A, bg, ba are 0.
- Encoding:
  - ACT: act_n = 0, A = row.
  - WR: A[16:14] = 100, A[COLWIDTH-1:0] = col.
  - RD: A[16:14] = 101, A[COLWIDTH-1:0] = col.
  - PRE: A[16:14] = 010, A10 = 0 (single bank).
  - All other A bits are 0.
- States: IDLE, ACT, WAIT_RCD, CAS, BURST, WAIT_PRE, PRE, WAIT_RP, plus ACT2 and WAIT_RAS2 (RowClone only).
- Read/write path: IDLE → ACT → WAIT_RCD → CAS → BURST → WAIT_PRE → PRE → WAIT_RP → IDLE.
- RowClone path: IDLE → ACT → WAIT_RAS2 → ACT2 (act_n = 0, A = row2) → WAIT_PRE → PRE → WAIT_RP → IDLE.
- A single free-running cycle count t (reset to 0 at ACT) drives all waits. Compare in CNTWIDTH bits; parameters must satisfy every sum < 2^CNTWIDTH.
- Op 11, or op 10 with RowClone compiled out: the request is accepted, err pulses in the following cycle, no command is issued, and the sequencer stays in IDLE.
- done pulses in the cycle WAIT_RP exits. req_ready is 1 on that same edge.

## Timing
All times are cycles relative to the ACT edge (t = 0). The request is accepted at t = −1.
- Write:
  - WR at t = TRCD.
  - writing = 1 for t = TRCD … TRCD+BL−1.
  - PRE at t = max(TRAS, TRCD+BL+TWR).
- Read:
  - RD at t = TRCD.
  - rd_valid = 1 for t = TRCD+TCL … TRCD+TCL+BL−1.
  - PRE at t = max(TRAS, TRCD+TCL+BL).
- RowClone:
  - ACT2 at t = TRAS.
  - PRE at t = 2·TRAS.
- For every op, IDLE and req_ready = 1 at t = PRE+TRP, with done pulsing in the same cycle.
- Back-to-back requests: the next ACT can be at the earliest 1 cycle after req_ready returns.
- Reset values (also apply on the edge after reset is asserted mid-operation):
  - cs_n all-1, act_n = 1, A = 0, bg = 0, ba = 0.
  - writing = 0, rd_valid = 0, done = 0, err = 0.
  - state IDLE, so req_ready = 1 once reset deasserts.
  - The in-flight sequence is abandoned and no PRE is issued.

## Configuration
- ROWCLONE_EN defined:
  - op 10 runs the RowClone path.
  - ACT2 and WAIT_RAS2 are present.
- ROWCLONE_EN undefined:
  - ACT2 and WAIT_RAS2 are removed and req_row2 is ignored.
  - op 10 is rejected with err.

## Test plan
- Write with defaults: bg = 1, ba = 1, row = 1, col = 2.
  - ACT at t = 0 with A = 0x00001.
  - WR at t = 15 with A = 0x10002; writing for t = 15–22.
  - PRE at t = 39 with A = 0x08000.
  - done and req_ready at t = 54.
- Read with the same address:
  - RD at t = 15 with A = 0x14002.
  - rd_valid for t = 30–37.
  - PRE at t = 38; done at t = 53.
- RowClone with ROWCLONE_EN, row = 1, row2 = 4:
  - ACT A = 0x00001 at t = 0.
  - ACT A = 0x00004 at t = 32.
  - PRE at t = 64; done at t = 79.
  - Without ROWCLONE_EN: err pulse, cs_n stays all-1, req_ready stays 1.
- Hold req_valid high with two writes queued:
  - The second write is accepted only at t = 54.
  - Its ACT appears at t = 55.
  - req_ready stays 0 from t = 0 to 53.
- Assert reset at t = 18 during a write burst:
  - The next edge gives writing = 0, cs_n all-1, act_n = 1.
  - No PRE is issued.
  - req_ready = 1 after reset deasserts.

Source files
------------

// File: rtl/dimm_cmd_sequencer.sv
// dimm_cmd_sequencer
//   Closed-page DDR4 command sequencer. Takes one read, write or RowClone
//   request at a time and drives ACT -> CAS -> PRE (or ACT -> ACT2 -> PRE
//   for RowClone) on the DIMM command/address pins. It also frames the
//   write-data drive window and flags the cycles where read beats arrive.
//
//   Build option: define ROWCLONE_EN to enable the RowClone path (op 10).
//   Without it, op 10 is rejected with err, just like op 11.
//
// Ports
//   ck_t, reset          clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_op               00 read, 01 write, 10 RowClone, 11 reserved
//   req_rank/bg/ba       one-hot rank, bank group, bank
//   req_row/row2/col     row, RowClone destination row, column
//   cs_n/act_n/A/bg/ba   DIMM command/address pins
//   writing              write data/strobe drive window
//   rd_valid             read beat expected on dq
//   done / err           one-cycle pulses: sequence complete / op rejected
module dimm_cmd_sequencer #(
  parameter int RANKS     = 1,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 15,
  parameter int TCL       = 15,
  parameter int TWR       = 16,
  parameter int TRAS      = 32,
  parameter int TRP       = 15,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 ck_t,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [RANKS-1:0]     req_rank,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [ADDRWIDTH-1:0] req_row2,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic [RANKS-1:0]     cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 writing,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 err
);

  // state     | meaning
  // IDLE      | ready for a request
  // ACT       | activate command, t = 0
  // WAIT_RCD  | waiting for tRCD
  // CAS       | RD or WR command, t = TRCD
  // BURST     | data beats in flight
  // WAIT_PRE  | holding the row open until the PRE time
  // PRE       | precharge command
  // WAIT_RP   | waiting for tRP, then done
  // WAIT_RAS2 | RowClone: waiting tRAS before the second ACT
  // ACT2      | RowClone: activate destination row
  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_BURST,
    S_WAIT_PRE,
    S_PRE,
`ifdef ROWCLONE_EN
    S_WAIT_RAS2,
    S_ACT2,
`endif
    S_WAIT_RP
  } state_t;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam int T_PRE_WR = (TRAS > TRCD + BL + TWR) ? TRAS : (TRCD + BL + TWR);
  localparam int T_PRE_RD = (TRAS > TRCD + TCL + BL) ? TRAS : (TRCD + TCL + BL);

  localparam logic [CNTWIDTH-1:0] C_ONE    = CNTWIDTH'(1);
  localparam logic [CNTWIDTH-1:0] C_RCD_M1 = CNTWIDTH'(TRCD - 1);
  localparam logic [CNTWIDTH-1:0] C_WR_END = CNTWIDTH'(TRCD + BL - 1);
  localparam logic [CNTWIDTH-1:0] C_RD_BEG = CNTWIDTH'(TRCD + TCL);
  localparam logic [CNTWIDTH-1:0] C_RD_END = CNTWIDTH'(TRCD + TCL + BL - 1);
  localparam logic [CNTWIDTH-1:0] C_PRE_WR = CNTWIDTH'(T_PRE_WR);
  localparam logic [CNTWIDTH-1:0] C_PRE_RD = CNTWIDTH'(T_PRE_RD);
  localparam logic [CNTWIDTH-1:0] C_TRP_M1 = CNTWIDTH'(TRP - 1);
`ifdef ROWCLONE_EN
  localparam logic [1:0]          OP_RC    = 2'b10;
  localparam logic [CNTWIDTH-1:0] C_RAS_M1 = CNTWIDTH'(TRAS - 1);
  localparam logic [CNTWIDTH-1:0] C_PRE_RC = CNTWIDTH'(2 * TRAS);
`endif

  state_t                r_state, w_state_nxt;
  logic [CNTWIDTH-1:0]   r_t;
  logic [1:0]            r_op;
  logic [RANKS-1:0]      r_rank;
  logic [BGWIDTH-1:0]    r_bg;
  logic [BAWIDTH-1:0]    r_ba;
  logic [ADDRWIDTH-1:0]  r_row;
  logic [COLWIDTH-1:0]   r_col;
  logic                  r_done, r_err;
  logic                  w_done_nxt;
  logic                  w_accept, w_op_ok;
  logic [CNTWIDTH-1:0]   w_t_pre, w_pre_m1, w_rp_end, w_data_end;

`ifdef ROWCLONE_EN
  logic [ADDRWIDTH-1:0]  r_row2;
  assign w_op_ok = (req_op != 2'b11);
  assign w_t_pre = (r_op == OP_RC) ? C_PRE_RC : (r_op == OP_WR) ? C_PRE_WR : C_PRE_RD;
`else
  logic                  w_unused_row2;
  assign w_unused_row2 = ^req_row2;
  assign w_op_ok = (req_op[1] == 1'b0);
  assign w_t_pre = (r_op == OP_WR) ? C_PRE_WR : C_PRE_RD;
`endif

  assign w_accept   = (r_state == S_IDLE) & req_valid;
  assign w_pre_m1   = w_t_pre - C_ONE;
  assign w_rp_end   = w_t_pre + C_TRP_M1;
  assign w_data_end = (r_op == OP_WR) ? C_WR_END : C_RD_END;

  assign req_ready = (r_state == S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge ck_t) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_op    <= OP_RD;
      r_rank  <= '0;
      r_bg    <= '0;
      r_ba    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef ROWCLONE_EN
      r_row2  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_accept & ~w_op_ok;
      // t restarts on acceptance so that it reads 0 in the ACT cycle
      r_t     <= (w_accept & w_op_ok) ? '0 : r_t + C_ONE;
      if (w_accept) begin
        r_op   <= req_op;
        r_rank <= req_rank;
        r_bg   <= req_bg;
        r_ba   <= req_ba;
        r_row  <= req_row;
        r_col  <= req_col;
`ifdef ROWCLONE_EN
        r_row2 <= req_row2;
`endif
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    cs_n        = '1;
    act_n       = 1'b1;
    A           = '0;
    bg          = '0;
    ba          = '0;
    writing     = 1'b0;
    rd_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept & w_op_ok) w_state_nxt = S_ACT;
      end
      S_ACT: begin
        cs_n  = ~r_rank;
        bg    = r_bg;
        ba    = r_ba;
        act_n = 1'b0;
        A     = r_row;
`ifdef ROWCLONE_EN
        w_state_nxt = (r_op == OP_RC) ? S_WAIT_RAS2 : S_WAIT_RCD;
`else
        w_state_nxt = S_WAIT_RCD;
`endif
      end
      S_WAIT_RCD: begin
        if (r_t == C_RCD_M1) w_state_nxt = S_CAS;
      end
      S_CAS: begin
        cs_n    = ~r_rank;
        bg      = r_bg;
        ba      = r_ba;
        A[16:14] = (r_op == OP_WR) ? 3'b100 : 3'b101;
        A[COLWIDTH-1:0] = r_col;
        writing = (r_op == OP_WR);
        w_state_nxt = S_BURST;
      end
      S_BURST: begin
        writing  = (r_op == OP_WR);
        rd_valid = (r_op == OP_RD) & (r_t >= C_RD_BEG);
        // a read whose last beat lands right before PRE skips WAIT_PRE
        if (r_t == w_pre_m1)        w_state_nxt = S_PRE;
        else if (r_t == w_data_end) w_state_nxt = S_WAIT_PRE;
      end
      S_WAIT_PRE: begin
        if (r_t == w_pre_m1) w_state_nxt = S_PRE;
      end
      S_PRE: begin
        cs_n     = ~r_rank;
        bg       = r_bg;
        ba       = r_ba;
        A[16:14] = 3'b010;
        w_state_nxt = S_WAIT_RP;
      end
      S_WAIT_RP: begin
        if (r_t == w_rp_end) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
`ifdef ROWCLONE_EN
      S_WAIT_RAS2: begin
        if (r_t == C_RAS_M1) w_state_nxt = S_ACT2;
      end
      S_ACT2: begin
        cs_n  = ~r_rank;
        bg    = r_bg;
        ba    = r_ba;
        act_n = 1'b0;
        A     = r_row2;
        w_state_nxt = S_WAIT_PRE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dimm_cmd_sequencer.sv
// Bench for dimm_cmd_sequencer: a timeline model (outputs as a function of
// cycles since ACT) is compared on every cycle, and directed tests pin the
// model with hand-computed command times and addresses.
module tb_dimm_cmd_sequencer;
  localparam int RANKS = 1, BGWIDTH = 2, BAWIDTH = 2, ADDRWIDTH = 17, COLWIDTH = 10;
  localparam int BL = 8, TRCD = 15, TCL = 15, TWR = 16, TRAS = 32, TRP = 15, CNTWIDTH = 8;
  localparam int NOBS = 200;

  logic                 ck_t = 1'b0;
  logic                 reset = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [1:0]           req_op = 2'b00;
  logic [RANKS-1:0]     req_rank = 1'b1;
  logic [BGWIDTH-1:0]   req_bg = '0;
  logic [BAWIDTH-1:0]   req_ba = '0;
  logic [ADDRWIDTH-1:0] req_row = '0;
  logic [ADDRWIDTH-1:0] req_row2 = '0;
  logic [COLWIDTH-1:0]  req_col = '0;
  logic [RANKS-1:0]     cs_n;
  logic                 act_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic                 writing, rd_valid, done, err;

  dimm_cmd_sequencer #(
    .RANKS(RANKS), .BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ADDRWIDTH(ADDRWIDTH),
    .COLWIDTH(COLWIDTH), .BL(BL), .TRCD(TRCD), .TCL(TCL), .TWR(TWR),
    .TRAS(TRAS), .TRP(TRP), .CNTWIDTH(CNTWIDTH)
  ) dut (
    .ck_t(ck_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_row2(req_row2), .req_col(req_col),
    .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .writing(writing), .rd_valid(rd_valid), .done(done), .err(err)
  );

  always #5 ck_t = ~ck_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic bit op_ok(input logic [1:0] op);
`ifdef ROWCLONE_EN
    return op != 2'b11;
`else
    return op[1] == 1'b0;
`endif
  endfunction

  function automatic int tpre_of(input logic [1:0] op);
    if (op == 2'b01) return (TRAS > TRCD + BL + TWR) ? TRAS : TRCD + BL + TWR;
    if (op == 2'b00) return (TRAS > TRCD + TCL + BL) ? TRAS : TRCD + TCL + BL;
    return 2 * TRAS;
  endfunction

  bit                   m_init = 0, m_active = 0, m_done = 0, m_err = 0;
  int                   m_t = 0, m_end = 0;
  logic [1:0]           m_op;
  logic [RANKS-1:0]     m_rank;
  logic [BGWIDTH-1:0]   m_bg;
  logic [BAWIDTH-1:0]   m_ba;
  logic [ADDRWIDTH-1:0] m_row, m_row2;
  logic [COLWIDTH-1:0]  m_col;

  always @(posedge ck_t) begin
    if (reset) begin
      m_init = 1; m_active = 0; m_done = 0; m_err = 0;
    end else if (m_init) begin
      m_done = 0; m_err = 0;
      if (m_active) begin
        m_t++;
        if (m_t == m_end) begin m_active = 0; m_done = 1; end
      end else if (req_valid) begin
        if (op_ok(req_op)) begin
          m_active = 1; m_t = 0; m_op = req_op; m_rank = req_rank;
          m_bg = req_bg; m_ba = req_ba; m_row = req_row; m_row2 = req_row2;
          m_col = req_col; m_end = tpre_of(req_op) + TRP;
        end else m_err = 1;
      end
    end
  end

  logic [RANKS-1:0]     e_cs;
  logic                 e_actn, e_wr, e_rd;
  logic [ADDRWIDTH-1:0] e_a;
  logic [BGWIDTH-1:0]   e_bg;
  logic [BAWIDTH-1:0]   e_ba;
  logic [27:0]          v_act, v_exp;

  always @(negedge ck_t) begin
    if (m_init) begin
      e_cs = '1; e_actn = 1; e_a = '0; e_bg = '0; e_ba = '0; e_wr = 0; e_rd = 0;
      if (m_active) begin
        if (m_t == 0 || (m_op == 2'b10 && m_t == TRAS) || (m_op != 2'b10 && m_t == TRCD)
            || m_t == tpre_of(m_op)) begin
          e_cs = ~m_rank; e_bg = m_bg; e_ba = m_ba;
        end
        if (m_t == 0) begin
          e_actn = 0; e_a = m_row;
        end else if (m_op == 2'b10 && m_t == TRAS) begin
          e_actn = 0; e_a = m_row2;
        end else if (m_op != 2'b10 && m_t == TRCD) begin
          e_a = (m_op == 2'b01) ? 17'h10000 : 17'h14000;
          e_a[COLWIDTH-1:0] = m_col;
        end else if (m_t == tpre_of(m_op)) begin
          e_a = 17'h08000;
        end
        e_wr = (m_op == 2'b01) && m_t >= TRCD && m_t < TRCD + BL;
        e_rd = (m_op == 2'b00) && m_t >= TRCD + TCL && m_t < TRCD + TCL + BL;
      end
      v_act = {req_ready, cs_n, act_n, A, bg, ba, writing, rd_valid, done, err};
      v_exp = {!m_active, e_cs, e_actn, e_a, e_bg, e_ba, e_wr, e_rd, m_done, m_err};
      n_cmp++;
      if (v_act !== v_exp) begin
        n_bad++;
        if (n_bad < 20)
          $display("FAIL cycle_model @%0t: got %07h expected %07h (rdy,cs,act,A,bg,ba,wr,rd,done,err)",
                   $time, v_act, v_exp);
      end
    end
  end

  // ---------------- directed observation ----------------
  bit                   o_ready[NOBS], o_wr[NOBS], o_rd[NOBS], o_done[NOBS], o_err[NOBS];
  bit                   o_cmd[NOBS], o_actn[NOBS];
  logic [ADDRWIDTH-1:0] o_a[NOBS];
  logic [BGWIDTH-1:0]   o_bg[NOBS];
  logic [BAWIDTH-1:0]   o_ba[NOBS];

  int c_n, c_t[8], c_a[8], c_actn[8], c_bg[8], c_ba[8];
  int wr_first, wr_last, rd_first, rd_last, done_first, done_cnt, err_cnt, rdy_low;

  task automatic start(input logic [1:0] op, input int bgv, input int bav,
                       input int row, input int row2, input int col);
    @(negedge ck_t);
    req_op = op; req_bg = BGWIDTH'(bgv); req_ba = BAWIDTH'(bav);
    req_row = ADDRWIDTH'(row); req_row2 = ADDRWIDTH'(row2); req_col = COLWIDTH'(col);
    req_valid = 1'b1;
    @(posedge ck_t);
  endtask

  task automatic observe(input int t_from, input int t_to, input int drop_at,
                         input int rst_on, input int rst_off);
    for (int t = t_from; t <= t_to; t++) begin
      @(negedge ck_t);
      o_ready[t] = req_ready; o_wr[t] = writing; o_rd[t] = rd_valid;
      o_done[t] = done; o_err[t] = err; o_cmd[t] = (cs_n != '1);
      o_actn[t] = act_n; o_a[t] = A; o_bg[t] = bg; o_ba[t] = ba;
      if (t == drop_at) req_valid = 1'b0;
      if (t == rst_on)  reset = 1'b1;
      if (t == rst_off) reset = 1'b0;
    end
  endtask

  task automatic scan(input int t_to);
    c_n = 0; wr_first = -1; wr_last = -1; rd_first = -1; rd_last = -1;
    done_first = -1; done_cnt = 0; err_cnt = 0; rdy_low = 0;
    for (int t = 0; t <= t_to; t++) begin
      if (o_cmd[t]) begin
        if (c_n < 8) begin
          c_t[c_n] = t; c_a[c_n] = int'(o_a[t]); c_actn[c_n] = int'(o_actn[t]);
          c_bg[c_n] = int'(o_bg[t]); c_ba[c_n] = int'(o_ba[t]);
        end
        c_n++;
      end
      if (o_wr[t]) begin if (wr_first < 0) wr_first = t; wr_last = t; end
      if (o_rd[t]) begin if (rd_first < 0) rd_first = t; rd_last = t; end
      if (o_done[t]) begin if (done_first < 0) done_first = t; done_cnt++; end
      if (o_err[t]) err_cnt++;
      if (!o_ready[t]) rdy_low++;
    end
  endtask

  initial begin
    repeat (3) @(negedge ck_t);
    reset = 1'b0;
    repeat (2) @(negedge ck_t);
    check("reset_ready", int'(req_ready), 1);
    check("reset_cs_n", int'(cs_n), 1);

    // write bg=1 ba=1 row=1 col=2
    start(2'b01, 1, 1, 1, 0, 2);
    observe(0, 59, 0, -1, -1);
    scan(59);
    check("wr_ncmd", c_n, 3);
    check("wr_act_t", c_t[0], 0);
    check("wr_act_a", c_a[0], 32'h00001);
    check("wr_act_n", c_actn[0], 0);
    check("wr_act_bg", c_bg[0], 1);
    check("wr_act_ba", c_ba[0], 1);
    check("wr_cas_t", c_t[1], 15);
    check("wr_cas_a", c_a[1], 32'h10002);
    check("wr_cas_actn", c_actn[1], 1);
    check("wr_pre_t", c_t[2], 39);
    check("wr_pre_a", c_a[2], 32'h08000);
    check("wr_win_first", wr_first, 15);
    check("wr_win_last", wr_last, 22);
    check("wr_done_t", done_first, 54);
    check("wr_ready_low", rdy_low, 54);
    check("wr_ready_t54", int'(o_ready[54]), 1);

    // read, same address
    start(2'b00, 1, 1, 1, 0, 2);
    observe(0, 59, 0, -1, -1);
    scan(59);
    check("rd_ncmd", c_n, 3);
    check("rd_cas_t", c_t[1], 15);
    check("rd_cas_a", c_a[1], 32'h14002);
    check("rd_win_first", rd_first, 30);
    check("rd_win_last", rd_last, 37);
    check("rd_pre_t", c_t[2], 38);
    check("rd_done_t", done_first, 53);

    // RowClone row=1 -> row2=4
    start(2'b10, 0, 2, 1, 4, 0);
    observe(0, 89, 0, -1, -1);
    scan(89);
`ifdef ROWCLONE_EN
    check("rc_ncmd", c_n, 3);
    check("rc_act_a", c_a[0], 32'h00001);
    check("rc_act2_t", c_t[1], 32);
    check("rc_act2_a", c_a[1], 32'h00004);
    check("rc_act2_n", c_actn[1], 0);
    check("rc_pre_t", c_t[2], 64);
    check("rc_pre_a", c_a[2], 32'h08000);
    check("rc_done_t", done_first, 79);
`else
    check("rc_off_ncmd", c_n, 0);
    check("rc_off_err_t0", int'(o_err[0]), 1);
    check("rc_off_err_cnt", err_cnt, 1);
    check("rc_off_ready_low", rdy_low, 0);
`endif

    // reserved op
    start(2'b11, 1, 0, 7, 0, 3);
    observe(0, 10, 0, -1, -1);
    scan(10);
    check("op11_ncmd", c_n, 0);
    check("op11_err_t0", int'(o_err[0]), 1);
    check("op11_err_cnt", err_cnt, 1);
    check("op11_ready_low", rdy_low, 0);

    // two writes with req_valid held
    start(2'b01, 2, 3, 1, 0, 5);
    observe(0, 0, -1, -1, -1);
    req_row = 17'd2;
    observe(1, 119, 55, -1, -1);
    scan(119);
    check("b2b_ready_low_first", rdy_low >= 54 ? int'(o_ready[53]) : 1, 0);
    check("b2b_ready_t54", int'(o_ready[54]), 1);
    check("b2b_ready_t55", int'(o_ready[55]), 0);
    check("b2b_ncmd", c_n, 6);
    check("b2b_act2_t", c_t[3], 55);
    check("b2b_act2_a", c_a[3], 32'h00002);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_done_first", done_first, 54);

    // reset in the middle of a write burst
    start(2'b01, 1, 1, 9, 0, 1);
    observe(0, 79, 0, 18, 20);
    scan(79);
    check("rst_wr_t18", int'(o_wr[18]), 1);
    check("rst_wr_t19", int'(o_wr[19]), 0);
    check("rst_cmd_t19", int'(o_cmd[19]), 0);
    check("rst_actn_t19", int'(o_actn[19]), 1);
    check("rst_ncmd", c_n, 2);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_ready_t21", int'(o_ready[21]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
